// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the Connect Four VGA display.
// Produces the pixel-rate strobe, horizontal/vertical counters, active-low
// syncs, the visible-area flag and a start-of-frame pulse.
// Optional build macro: VGA_FRAME_COUNT_EN adds a 16-bit frame counter port.
module vga_timing #(
  parameter int CLK_DIV      = 2,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_VIS_START  = 158,
  parameter int H_VIS_END    = 798,
  parameter int V_TOTAL      = 525,
  parameter int V_VIS_END    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        pix_en,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        bright,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  // Parameter values cast once to the counter widths so every compare is width-matched.
  localparam logic [1:0] DIV_LAST       = 2'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST         = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST         = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W       = 10'(H_SYNC);
  localparam logic [9:0] H_VIS_START_W  = 10'(H_VIS_START);
  localparam logic [9:0] H_VIS_END_W    = 10'(H_VIS_END);
  localparam logic [9:0] V_VIS_END_W    = 10'(V_VIS_END);
  localparam logic [9:0] V_SYNC_START_W = 10'(V_SYNC_START);
  localparam logic [9:0] V_SYNC_END_W   = 10'(V_SYNC_END);

  logic [1:0] div_reg, div_next;
  logic       pix_en_reg, pix_en_next;
  logic [9:0] hcount_reg, hcount_next;
  logic [9:0] vcount_reg, vcount_next;
  logic       hsync_reg, hsync_next;
  logic       vsync_reg, vsync_next;
  logic       bright_reg, bright_next;
  logic       frame_start_reg, frame_start_next;
  logic       h_wrap, v_wrap;

  // Next-state: divider, counters, and decode of the values about to be loaded.
  always_comb begin
    div_next    = (div_reg == DIV_LAST) ? 2'd0 : div_reg + 2'd1;
    // Strobe is registered so it is high exactly while the divider sits at its last count.
    pix_en_next = (div_next == DIV_LAST);

    h_wrap      = (hcount_reg == H_LAST);
    v_wrap      = (vcount_reg == V_LAST);
    hcount_next = hcount_reg;
    vcount_next = vcount_reg;
    if (pix_en_reg) begin
      if (h_wrap) begin
        hcount_next = 10'd0;
        vcount_next = v_wrap ? 10'd0 : vcount_reg + 10'd1;
      end else begin
        hcount_next = hcount_reg + 10'd1;
      end
    end

    // Decoding next-state values keeps syncs and bright aligned with the counters.
    hsync_next       = !(hcount_next < H_SYNC_W);
    vsync_next       = !((vcount_next >= V_SYNC_START_W) && (vcount_next < V_SYNC_END_W));
    bright_next      = (hcount_next >= H_VIS_START_W) && (hcount_next < H_VIS_END_W) &&
                       (vcount_next < V_VIS_END_W);
    frame_start_next = pix_en_reg && h_wrap && v_wrap;
  end

  // State and output registers; reset forces the line-start/no-frame condition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_reg         <= 2'd0;
      pix_en_reg      <= 1'b0;
      hcount_reg      <= 10'd0;
      vcount_reg      <= 10'd0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b1;
      bright_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= div_next;
      pix_en_reg      <= pix_en_next;
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      bright_reg      <= bright_next;
      frame_start_reg <= frame_start_next;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_reg;

  // Frame counter bumps on the same edge that loads (0,0); wraps naturally at 0xFFFF.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_reg <= 16'd0;
    end else if (frame_start_next) begin
      frame_count_reg <= frame_count_reg + 16'd1;
    end
  end

  assign frame_count = frame_count_reg;
`endif

  assign pix_en      = pix_en_reg;
  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign bright      = bright_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: checks two vga_timing builds against a cycle-arithmetic model.
// Instance A: CLK_DIV=2 with a shrunken raster; instance B: CLK_DIV=1 with the
// full 800-pixel line and a short frame. Frame counter checked when
// VGA_FRAME_COUNT_EN is defined.
module tb_vga_timing;

  // Instance A parameters (small raster so full frames fit in the run)
  localparam int A_D = 2, A_HT = 20, A_HS = 3, A_HVS = 5, A_HVE = 17;
  localparam int A_VT = 12, A_VVE = 8, A_VSS = 9, A_VSE = 10;
  // Instance B parameters (full line timing, short frame)
  localparam int B_D = 1, B_HT = 800, B_HS = 96, B_HVS = 158, B_HVE = 798;
  localparam int B_VT = 6, B_VVE = 4, B_VSS = 4, B_VSE = 5;

  typedef struct packed {
    logic        pe;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

  typedef struct {
    int   inst;
    int   k;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  logic       pix_en_a, hsync_a, vsync_a, bright_a, frame_start_a;
  logic [9:0] hcount_a, vcount_a;
  logic       pix_en_b, hsync_b, vsync_b, bright_b, frame_start_b;
  logic [9:0] hcount_b, vcount_b;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_a, frame_count_b;
`endif

  vga_timing #(
    .CLK_DIV(A_D), .H_TOTAL(A_HT), .H_SYNC(A_HS), .H_VIS_START(A_HVS), .H_VIS_END(A_HVE),
    .V_TOTAL(A_VT), .V_VIS_END(A_VVE), .V_SYNC_START(A_VSS), .V_SYNC_END(A_VSE)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en_a), .hcount(hcount_a), .vcount(vcount_a),
    .hsync(hsync_a), .vsync(vsync_a), .bright(bright_a), .frame_start(frame_start_a)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count_a)
`endif
  );

  vga_timing #(
    .CLK_DIV(B_D), .H_TOTAL(B_HT), .H_SYNC(B_HS), .H_VIS_START(B_HVS), .H_VIS_END(B_HVE),
    .V_TOTAL(B_VT), .V_VIS_END(B_VVE), .V_SYNC_START(B_VSS), .V_SYNC_END(B_VSE)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en_b), .hcount(hcount_b), .vcount(vcount_b),
    .hsync(hsync_b), .vsync(vsync_b), .bright(bright_b), .frame_start(frame_start_b)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count_b)
`endif
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];
  vec_t vecs[$];

  // measurements (first run after power-on reset)
  int br_b = 0, hs_b = 0, vs_a = 0, bad_a = 0, pe0_b = 0;
  int fs_a_k[2];
  int fs_a_n = 0;
  int fs_b_first = -1;
  int wrap_k[2];
  int wrap_n = 0;
  int prev_hb = 0;

  // Expected outputs k clock edges after reset release, computed from elapsed time.
  function automatic exp_t model(int k, int d, int ht, int hs, int hvs, int hve,
                                 int vt, int vve, int vss, int vse);
    exp_t e;
    int n, np, h, v;
    if (d == 1) begin
      n  = (k > 0) ? k - 1 : 0;
      np = (k > 1) ? k - 2 : 0;
    end else begin
      n  = k / d;
      np = (k > 0) ? (k - 1) / d : 0;
    end
    h    = n % ht;
    v    = (n / ht) % vt;
    e.pe = (k >= 1) && ((k % d) == d - 1);
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = !(h < hs);
    e.vs = !((v >= vss) && (v < vse));
    e.br = (h >= hvs) && (h < hve) && (v < vve);
    e.fs = (k > 0) && (n != np) && ((n % (ht * vt)) == 0);
`ifdef VGA_FRAME_COUNT_EN
    e.fc = 16'((n / (ht * vt)) % 65536);
`else
    e.fc = 16'd0;
`endif
    return e;
  endfunction

  function automatic exp_t model_a(int k);
    return model(k, A_D, A_HT, A_HS, A_HVS, A_HVE, A_VT, A_VVE, A_VSS, A_VSE);
  endfunction

  function automatic exp_t model_b(int k);
    return model(k, B_D, B_HT, B_HS, B_HVS, B_HVE, B_VT, B_VVE, B_VSS, B_VSE);
  endfunction

  function automatic exp_t grab_a();
    exp_t e;
    e.pe = pix_en_a; e.h = hcount_a; e.v = vcount_a;
    e.hs = hsync_a; e.vs = vsync_a; e.br = bright_a; e.fs = frame_start_a;
`ifdef VGA_FRAME_COUNT_EN
    e.fc = frame_count_a;
`else
    e.fc = 16'd0;
`endif
    return e;
  endfunction

  function automatic exp_t grab_b();
    exp_t e;
    e.pe = pix_en_b; e.h = hcount_b; e.v = vcount_b;
    e.hs = hsync_b; e.vs = vsync_b; e.br = bright_b; e.fs = frame_start_b;
`ifdef VGA_FRAME_COUNT_EN
    e.fc = frame_count_b;
`else
    e.fc = 16'd0;
`endif
    return e;
  endfunction

  task automatic chk(string name, int k, exp_t act, exp_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got pe=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b fc=%0d | want pe=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b fc=%0d",
               name, k, act.pe, act.h, act.v, act.hs, act.vs, act.br, act.fs, act.fc,
               exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.fs, exp.fc);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic add(int inst, int k, logic pe, int h, int v, logic hs, logic vs,
                     logic br, logic fs);
    vec_t r;
    r.inst = inst; r.k = k;
    r.e.pe = pe; r.e.h = 10'(h); r.e.v = 10'(v);
    r.e.hs = hs; r.e.vs = vs; r.e.br = br; r.e.fs = fs; r.e.fc = 16'd0;
    vecs.push_back(r);
  endtask

  // One clock per iteration: push expectation at the edge, pop and compare 1 time unit later.
  task automatic run_cycles(int kmax, bit measure);
    exp_t ea, eb, act_a, act_b, act;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      qa.push_back(model_a(k));
      qb.push_back(model_b(k));
      #1;
      act_a = grab_a();
      act_b = grab_b();
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("scb_a", k, act_a, ea);
      chk("scb_b", k, act_b, eb);
      foreach (vecs[i]) begin
        if (vecs[i].k == k) begin
          act = (vecs[i].inst == 0) ? act_a : act_b;
          act.fc = 16'd0;
          chk((vecs[i].inst == 0) ? "vec_a" : "vec_b", k, act, vecs[i].e);
          $display("vector inst=%0d k=%0d h=%0d v=%0d", vecs[i].inst, k, act.h, act.v);
        end
      end
      if (measure) begin
        if (k <= 800) begin
          if (bright_b) br_b++;
          if (!hsync_b) hs_b++;
        end
        if (k <= 479) begin
          if (!vsync_a) vs_a++;
          if (bright_a && vcount_a >= 10'(A_VVE)) bad_a++;
        end
        if (!pix_en_b) pe0_b++;
        if (frame_start_a && fs_a_n < 2) begin fs_a_k[fs_a_n] = k; fs_a_n++; end
        if (frame_start_b && fs_b_first < 0) fs_b_first = k;
        if (hcount_b == 10'd0 && prev_hb == 799 && wrap_n < 2) begin
          wrap_k[wrap_n] = k; wrap_n++;
        end
        prev_hb = int'(hcount_b);
`ifdef VGA_FRAME_COUNT_EN
        if (k == 480)  chk_int("frame_count_a_1", int'(frame_count_a), 1);
        if (k == 1440) chk_int("frame_count_a_3", int'(frame_count_a), 3);
`endif
      end
    end
  endtask

  initial begin
    // instance A vectors (k = clk edges since release)
    add(0,   0, 0,  0,  0, 0, 1, 0, 0);
    add(0,   1, 1,  0,  0, 0, 1, 0, 0);
    add(0,   2, 0,  1,  0, 0, 1, 0, 0);
    add(0,   6, 0,  3,  0, 1, 1, 0, 0);
    add(0,  10, 0,  5,  0, 1, 1, 1, 0);
    add(0,  34, 0, 17,  0, 1, 1, 0, 0);
    add(0,  40, 0,  0,  1, 0, 1, 0, 0);
    add(0, 330, 0,  5,  8, 1, 1, 0, 0);
    add(0, 360, 0,  0,  9, 0, 0, 0, 0);
    add(0, 400, 0,  0, 10, 0, 1, 0, 0);
    add(0, 478, 0, 19, 11, 1, 1, 0, 0);
    add(0, 480, 0,  0,  0, 0, 1, 0, 1);
    add(0, 481, 1,  0,  0, 0, 1, 0, 0);
    // instance B vectors
    add(1,    1, 1,   0, 0, 0, 1, 0, 0);
    add(1,    2, 1,   1, 0, 0, 1, 0, 0);
    add(1,   97, 1,  96, 0, 1, 1, 0, 0);
    add(1,  159, 1, 158, 0, 1, 1, 1, 0);
    add(1,  799, 1, 798, 0, 1, 1, 0, 0);
    add(1,  801, 1,   0, 1, 0, 1, 0, 0);
    add(1, 3601, 1, 400, 4, 1, 0, 0, 0);
    add(1, 4801, 1,   0, 0, 0, 1, 0, 1);
    add(1, 6701, 1, 300, 2, 1, 1, 1, 0);

    // power-on reset, held for 5 clocks
    #1 reset_n = 1'b0;
    #1;
    chk("reset_a", 0, grab_a(), model_a(0));
    chk("reset_b", 0, grab_b(), model_b(0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_hold_a", 0, grab_a(), model_a(0));
    chk("reset_hold_b", 0, grab_b(), model_b(0));
    reset_n = 1'b1;

    run_cycles(6701, 1'b1);

    chk_int("bright_px_line_b", br_b, 640);
    chk_int("hsync_low_px_b", hs_b, 96);
    chk_int("vsync_low_samples_a", vs_a, 2 * A_HT * (A_VSE - A_VSS));
    chk_int("bright_in_vblank_a", bad_a, 0);
    chk_int("pix_en_low_b", pe0_b, 0);
    chk_int("frame_period_a", (fs_a_n == 2) ? fs_a_k[1] - fs_a_k[0] : -1, A_HT * A_VT * A_D);
    chk_int("first_frame_start_b", fs_b_first, B_HT * B_VT + 1);
    chk_int("line_period_b", (wrap_n == 2) ? wrap_k[1] - wrap_k[0] : -1, B_HT * B_D);

    // mid-frame reset: B is at (300,2) here; reset must act without a clock edge
    reset_n = 1'b0;
    #1;
    chk("midreset_a", 0, grab_a(), model_a(0));
    chk("midreset_b", 0, grab_b(), model_b(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midreset_hold_b", 0, grab_b(), model_b(0));
    reset_n = 1'b1;
    run_cycles(20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
